// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the CPU/debug data-RAM arbiter.
package mem_arb_pkg;
    localparam int WEA_W  = 4;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
    typedef enum logic {MST_CPU = 1'b0, MST_DBG = 1'b1} mst_e;

    typedef struct packed {
        logic [WEA_W-1:0]  wea;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;
endpackage

// File: rtl/arb_starve_cnt.sv
// Counts debug-request cycles without a grant; starve forces the next grant to debug.
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic grant,
    output logic starve
);
    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!rst)
            count <= '0;
        else if (grant || !req)
            count <= '0;
        else if (count != 8'(MAX_WAIT))
            count <= count + 8'd1;
    end

    assign starve = (count == 8'(MAX_WAIT));
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port sync RAM between the CPU data port and a debug master.
// CPU wins ties; a debug master left waiting MAX_WAIT cycles wins the next arbitration.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RAM_LATENCY = 1,
    parameter int MAX_WAIT    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [WEA_W-1:0]  cpu_wea,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_ready,
    input  logic              dbg_req,
    input  logic [WEA_W-1:0]  dbg_wea,
    input  logic [DATA_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              ram_en,
    output logic [WEA_W-1:0]  ram_wea,
    output logic [DATA_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    arb_state_e        state, state_nx;
    mst_e              grant, grant_nx;
    logic              grant_wr;
    logic [1:0]        wait_cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              starve, cpu_win, dbg_win, resp_rd;
    mem_req_t          cpu_r, dbg_r, sel_r;

    assign cpu_r   = '{wea: cpu_wea, addr: cpu_addr, wdata: cpu_wdata};
    assign dbg_r   = '{wea: dbg_wea, addr: dbg_addr, wdata: dbg_wdata};
    assign cpu_win = cpu_req && !starve;
    assign dbg_win = dbg_req && (!cpu_req || starve);
    assign sel_r   = cpu_win ? cpu_r : dbg_r;

    arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk    (clk),
        .rst    (rst),
        .req    (dbg_req),
        .grant  (state == IDLE && !cpu_win && dbg_win),
        .starve (starve)
    );

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        unique case (state)
            IDLE: begin
                if (cpu_win) begin
                    state_nx = ISSUE;
                    grant_nx = MST_CPU;
                end else if (dbg_win) begin
                    state_nx = ISSUE;
                    grant_nx = MST_DBG;
                end
            end
            ISSUE:   state_nx = (grant_wr || RAM_LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (wait_cnt == 2'd0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // RAM port is registered at grant time: the master holds its inputs until ack,
    // so this equals muxing them during ISSUE without a comb path to the RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            grant     <= MST_CPU;
            grant_wr  <= 1'b0;
            wait_cnt  <= '0;
            rdata_q   <= '0;
            ram_en    <= 1'b0;
            ram_wea   <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state   <= state_nx;
            grant   <= grant_nx;
            ram_en  <= 1'b0;
            ram_wea <= '0;
            if (state == IDLE && state_nx == ISSUE) begin
                grant_wr  <= |sel_r.wea;
                ram_en    <= 1'b1;
                ram_wea   <= sel_r.wea;
                ram_addr  <= sel_r.addr;
                ram_wdata <= sel_r.wdata;
            end
            if (state == ISSUE)
                wait_cnt <= 2'(RAM_LATENCY - 2);
            else if (state == WAIT)
                wait_cnt <= wait_cnt - 2'd1;
            if (resp_rd)
                rdata_q <= ram_rdata;
        end
    end

    assign resp_rd   = (state == RESP) && !grant_wr;
    assign cpu_ack   = (state == RESP) && (grant == MST_CPU);
    assign dbg_ack   = (state == RESP) && (grant == MST_DBG);
    assign cpu_rdata = (resp_rd && grant == MST_CPU) ? ram_rdata : rdata_q;
    assign dbg_rdata = (resp_rd && grant == MST_DBG) ? ram_rdata : rdata_q;
    assign cpu_ready = !cpu_req || cpu_ack;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (latency 1 / max-wait 8 and latency 3 / max-wait 4)
// checked against a word-level shadow memory and cycle counts derived from the access rules.
module tb_mem_arbiter;
    localparam int ND = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic        cpu_req [ND], cpu_ack [ND], cpu_ready [ND];
    logic [3:0]  cpu_wea [ND];
    logic [31:0] cpu_addr [ND], cpu_wdata [ND], cpu_rdata [ND];
    logic        dbg_req [ND], dbg_ack [ND];
    logic [3:0]  dbg_wea [ND];
    logic [31:0] dbg_addr [ND], dbg_wdata [ND], dbg_rdata [ND];
    logic        ram_en [ND];
    logic [3:0]  ram_wea [ND];
    logic [31:0] ram_addr [ND], ram_wdata [ND];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int n_cpu_ack [ND], n_dbg_ack [ND], wea_cyc [ND], stray [ND];
    logic [31:0] shw [ND][64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar gd = 0; gd < ND; gd++) begin : g_dut
        localparam int L  = (gd == 0) ? 1 : 3;
        localparam int MW = (gd == 0) ? 8 : 4;
        logic [31:0] mem [64];
        logic [31:0] rpipe [L];
        logic [31:0] rdata;

        mem_arbiter #(.RAM_LATENCY(L), .MAX_WAIT(MW)) u_dut (
            .clk(clk), .rst(rst),
            .cpu_req(cpu_req[gd]), .cpu_wea(cpu_wea[gd]), .cpu_addr(cpu_addr[gd]),
            .cpu_wdata(cpu_wdata[gd]), .cpu_rdata(cpu_rdata[gd]), .cpu_ack(cpu_ack[gd]),
            .cpu_ready(cpu_ready[gd]),
            .dbg_req(dbg_req[gd]), .dbg_wea(dbg_wea[gd]), .dbg_addr(dbg_addr[gd]),
            .dbg_wdata(dbg_wdata[gd]), .dbg_rdata(dbg_rdata[gd]), .dbg_ack(dbg_ack[gd]),
            .ram_en(ram_en[gd]), .ram_wea(ram_wea[gd]), .ram_addr(ram_addr[gd]),
            .ram_wdata(ram_wdata[gd]), .ram_rdata(rdata)
        );

        // RAM model: data is valid exactly L cycles after the enable, X otherwise.
        always @(posedge clk) begin
            if (ram_en[gd])
                for (int b = 0; b < 4; b++)
                    if (ram_wea[gd][b]) mem[ram_addr[gd][7:2]][8*b +: 8] <= ram_wdata[gd][8*b +: 8];
            rpipe[0] <= ram_en[gd] ? mem[ram_addr[gd][7:2]] : 'x;
            for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
        end
        assign rdata = rpipe[L-1];
    end

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (cpu_ack[d]) n_cpu_ack[d]++;
            if (dbg_ack[d]) n_dbg_ack[d]++;
            if (ram_wea[d] != 4'h0) wea_cyc[d]++;
            if (ram_wea[d] != 4'h0 && !ram_en[d]) stray[d]++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int mw_of(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] wea);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (wea[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request from an IDLE cycle; returns cycles to ack (-1 on timeout) and ends in IDLE.
    task automatic xact(input int d, input bit dbg, input logic [3:0] wea, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rd);
        int c0;
        c0 = cyc;
        lat = -1;
        rd = 'x;
        if (dbg) begin
            dbg_req[d] = 1'b1; dbg_wea[d] = wea; dbg_addr[d] = addr; dbg_wdata[d] = wdata;
        end else begin
            cpu_req[d] = 1'b1; cpu_wea[d] = wea; cpu_addr[d] = addr; cpu_wdata[d] = wdata;
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (dbg ? dbg_ack[d] : cpu_ack[d]) begin
                lat = cyc - c0;
                rd = dbg ? dbg_rdata[d] : cpu_rdata[d];
                break;
            end
        end
        if (dbg) dbg_req[d] = 1'b0;
        else cpu_req[d] = 1'b0;
        step();
    endtask

    task automatic access(input int d, input bit dbg, input logic [3:0] wea, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        int lat;
        logic [31:0] rd;
        xact(d, dbg, wea, addr, wdata, lat, rd);
        chk($sformatf("%s_lat%0d", tag, d), lat, (wea != 4'h0) ? 2 : 1 + lat_of(d));
        if (wea == 4'h0) chk($sformatf("%s_rd%0d", tag, d), rd, shw[d][addr[7:2]]);
        else shw[d][addr[7:2]] = merge(shw[d][addr[7:2]], wdata, wea);
    endtask

    // CPU read 0x20 and debug write 0x24 raised together: CPU first, debug one read-spacing later.
    task automatic race(input int d);
        int c0, ci, di, ca, da, L;
        L = lat_of(d);
        ci = -1; di = -1; ca = -1; da = -1;
        c0 = cyc;
        cpu_req[d] = 1'b1; cpu_wea[d] = 4'h0; cpu_addr[d] = 32'h20;
        dbg_req[d] = 1'b1; dbg_wea[d] = 4'hF; dbg_addr[d] = 32'h24; dbg_wdata[d] = 32'h5A5A0000 + d;
        for (int i = 0; i < 20 && da < 0; i++) begin
            step();
            if (ram_en[d] && ram_addr[d] == 32'h20 && ci < 0) ci = cyc;
            if (ram_en[d] && ram_addr[d] == 32'h24 && di < 0) di = cyc;
            if (cpu_ack[d]) begin
                ca = cyc;
                chk($sformatf("race_cpu_rd%0d", d), cpu_rdata[d], shw[d][8]);
                cpu_req[d] = 1'b0;
            end
            if (dbg_ack[d]) begin
                da = cyc;
                dbg_req[d] = 1'b0;
            end
        end
        step();
        chk($sformatf("race_cpu_iss%0d", d), ci - c0, 1);
        chk($sformatf("race_cpu_ack%0d", d), ca - c0, 1 + L);
        chk($sformatf("race_dbg_iss%0d", d), di - c0, 1 + L + 2);
        chk($sformatf("race_dbg_ack%0d", d), da - c0, 2 + L + 2);
        shw[d][9] = 32'h5A5A0000 + d;
    endtask

    // Back-to-back CPU reads with debug waiting: debug wins the first IDLE at or after MAX_WAIT cycles.
    task automatic starve_run(input int d);
        int L, P, MW, k, c0, di, ncpu, cafter;
        L = lat_of(d); P = L + 2; MW = mw_of(d);
        k = (MW + P - 1) / P;
        if (k < 1) k = 1;
        di = -1; ncpu = 0; cafter = -1;
        c0 = cyc;
        cpu_req[d] = 1'b1; cpu_wea[d] = 4'h0; cpu_addr[d] = 32'h10;
        dbg_req[d] = 1'b1; dbg_wea[d] = 4'hF; dbg_addr[d] = 32'h28; dbg_wdata[d] = 32'hC0DE0000 + d;
        for (int i = 0; i < 60 && cafter < 0; i++) begin
            step();
            if (ram_en[d] && ram_addr[d] == 32'h28) begin
                di = cyc;
                if (d == 1) chk("starve_cnt_clr", 32'(g_dut[1].u_dut.u_starve.count), 0);
            end
            if (ram_en[d] && ram_addr[d] == 32'h10) begin
                if (di < 0) ncpu++;
                else cafter = cyc;
            end
            if (cpu_ack[d]) chk($sformatf("starve_cpu_rd%0d", d), cpu_rdata[d], shw[d][4]);
            if (dbg_ack[d]) dbg_req[d] = 1'b0;
        end
        cpu_req[d] = 1'b0;
        chk($sformatf("starve_dbg_iss%0d", d), di - c0, P * k + 1);
        chk($sformatf("starve_cpu_before%0d", d), ncpu, k);
        chk($sformatf("starve_cpu_after%0d", d), cafter - c0, P * k + 4);
        shw[d][10] = 32'hC0DE0000 + d;
        repeat (L + 3) step();
    endtask

    initial begin
        int a0, w0;
        logic [3:0] wea;
        for (int d = 0; d < ND; d++) begin
            cpu_req[d] = 1'b0; cpu_wea[d] = '0; cpu_addr[d] = '0; cpu_wdata[d] = '0;
            dbg_req[d] = 1'b0; dbg_wea[d] = '0; dbg_addr[d] = '0; dbg_wdata[d] = '0;
        end

        // Reset state
        repeat (3) step();
        for (int d = 0; d < ND; d++) begin
            chk("rst_ram_en", ram_en[d], 0);
            chk("rst_ram_wea", ram_wea[d], 0);
            chk("rst_ram_addr", ram_addr[d], 0);
            chk("rst_ram_wdata", ram_wdata[d], 0);
            chk("rst_cpu_ack", cpu_ack[d], 0);
            chk("rst_dbg_ack", dbg_ack[d], 0);
            chk("rst_cpu_rdata", cpu_rdata[d], 0);
            chk("rst_dbg_rdata", dbg_rdata[d], 0);
            chk("rst_cpu_ready", cpu_ready[d], 1);
        end
        cpu_req[0] = 1'b1;
        #1 chk("rst_ready_req", cpu_ready[0], 0);
        cpu_req[0] = 1'b0;
        rst = 1'b1;
        step();

        // Single CPU word write, latency-1 instance, cycle by cycle
        cpu_req[0] = 1'b1; cpu_wea[0] = 4'hF; cpu_addr[0] = 32'h10; cpu_wdata[0] = 32'hDEADBEEF;
        #1 chk("wr_ready_c", cpu_ready[0], 0);
        step();
        chk("wr_en_c1", ram_en[0], 1);
        chk("wr_wea_c1", ram_wea[0], 4'hF);
        chk("wr_addr_c1", ram_addr[0], 32'h10);
        chk("wr_wdata_c1", ram_wdata[0], 32'hDEADBEEF);
        chk("wr_ready_c1", cpu_ready[0], 0);
        chk("wr_noack_c1", cpu_ack[0], 0);
        step();
        chk("wr_ack_c2", cpu_ack[0], 1);
        chk("wr_ready_c2", cpu_ready[0], 1);
        chk("wr_en_c2", ram_en[0], 0);
        chk("wr_wea_c2", ram_wea[0], 0);
        cpu_req[0] = 1'b0;
        step();
        chk("wr_ack_c3", cpu_ack[0], 0);
        chk("wr_addr_hold", ram_addr[0], 32'h10);
        chk("wr_wdata_hold", ram_wdata[0], 32'hDEADBEEF);
        shw[0][4] = 32'hDEADBEEF;

        // Same write on the latency-3 instance, then reads back on both
        access(1, 1'b0, 4'hF, 32'h10, 32'hDEADBEEF, "wr");
        access(1, 1'b0, 4'h0, 32'h10, 32'h0, "rd");
        chk("rd_hold1", cpu_rdata[1], 32'hDEADBEEF);
        chk("rd_hold1_dbg", dbg_rdata[1], 32'hDEADBEEF);
        access(0, 1'b0, 4'h0, 32'h10, 32'h0, "rd");
        chk("rd_hold0", cpu_rdata[0], 32'hDEADBEEF);

        // Debug-master writes, then arbitration tests
        for (int d = 0; d < ND; d++) access(d, 1'b1, 4'hF, 32'h20, 32'h20200000 + d, "dbgwr");
        for (int d = 0; d < ND; d++) race(d);
        for (int d = 0; d < ND; d++) starve_run(d);

        // Reset while the latency-3 instance is in WAIT
        cpu_req[1] = 1'b1; cpu_wea[1] = 4'h0; cpu_addr[1] = 32'h10;
        step();
        chk("rstw_issue", ram_en[1], 1);
        step();
        chk("rstw_wait_en", ram_en[1], 0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        cpu_req[1] = 1'b0;
        a0 = n_cpu_ack[1];
        chk("rstw_rdata_q1", cpu_rdata[1], 0);
        chk("rstw_rdata_q0", cpu_rdata[0], 0);
        repeat (6) step();
        chk("rstw_no_ack", n_cpu_ack[1], a0);
        access(1, 1'b0, 4'h0, 32'h10, 32'h0, "rstw_rd");

        // Idle bus
        a0 = n_cpu_ack[0] + n_cpu_ack[1] + n_dbg_ack[0] + n_dbg_ack[1];
        for (int i = 0; i < 20; i++) begin
            step();
            for (int d = 0; d < ND; d++) begin
                chk("idle_ready", cpu_ready[d], 1);
                chk("idle_en", ram_en[d], 0);
                chk("idle_wea", ram_wea[d], 0);
            end
        end
        chk("idle_acks", n_cpu_ack[0] + n_cpu_ack[1] + n_dbg_ack[0] + n_dbg_ack[1], a0);

        // Byte write into lane 2
        access(1, 1'b0, 4'hF, 32'h30, 32'hA5A5A5A5, "bw_pre");
        w0 = wea_cyc[1];
        cpu_req[1] = 1'b1; cpu_wea[1] = 4'b0100; cpu_addr[1] = 32'h32; cpu_wdata[1] = 32'h77CC5511;
        step();
        chk("bw_en", ram_en[1], 1);
        chk("bw_wea", ram_wea[1], 4'b0100);
        chk("bw_addr", ram_addr[1], 32'h32);
        step();
        chk("bw_ack", cpu_ack[1], 1);
        chk("bw_wea_resp", ram_wea[1], 0);
        cpu_req[1] = 1'b0;
        step();
        chk("bw_wea_cycles", wea_cyc[1] - w0, 1);
        shw[1][12] = merge(shw[1][12], 32'h77CC5511, 4'b0100);
        access(1, 1'b0, 4'h0, 32'h30, 32'h0, "bw_rd");
        chk("bw_word", cpu_rdata[1], 32'hA5CCA5A5);

        // Randomized traffic against the shadow memory
        for (int d = 0; d < ND; d++)
            for (int j = 0; j < 16; j++)
                access(d, 1'b1, 4'hF, 32'h40 + 32'(j * 4), $urandom, "fill");
        for (int i = 0; i < 50; i++) begin
            for (int d = 0; d < ND; d++) begin
                case ($urandom_range(0, 3))
                    1: wea = 4'hF;
                    2: wea = 4'($urandom_range(1, 15));
                    default: wea = 4'h0;
                endcase
                access(d, 1'($urandom_range(0, 1)), wea,
                       32'h40 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3)),
                       $urandom, "rnd");
            end
        end

        for (int d = 0; d < ND; d++) chk("stray_wea", stray[d], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing one single-port synchronous data RAM between the CPU data port (MEM stage: Addr_out / Data_out / wea / Data_in) and a debug/loader master. It sequences each access through issue, wait and response phases, drives the RAM port, and generates the CPU stall signal that feeds MIO_ready. CPU has priority; the debug master gets a bounded-wait guarantee.

## Interface
- RAM_LATENCY, 1: cycles from RAM enable to valid ram_rdata; legal range 1..4.
- MAX_WAIT, 8: debug-request cycles without grant before debug wins the next arbitration; legal range 1..255.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset, sampled on rising clk.
- cpu_req  in  1  CPU access request; held stable until cpu_ack.
- cpu_wea  in  4  byte write enables; 0 means read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data, already lane-shifted.
- cpu_rdata  out  32  read data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_ready  out  1  !cpu_req | cpu_ack; drives MIO_ready.
- dbg_req, dbg_wea, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack: same widths, directions and rules as the cpu_* ports.
- ram_en  out  1  RAM access strobe.
- ram_wea  out  4  RAM byte write enables.
- ram_addr  out  32  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid RAM_LATENCY cycles after ram_en.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. A grant register holds the selected master (CPU/DBG) plus a captured read/write flag.
- IDLE: when cpu_req=1 and starve=0, grant CPU. When dbg_req=1 and either cpu_req=0 or starve=1, grant DBG. Otherwise stay in IDLE. Any grant moves the FSM to ISSUE.
- ISSUE (1 cycle): ram_en=1. ram_addr, ram_wea and ram_wdata mux from the granted master's inputs. Next state: RESP if the access is a write or RAM_LATENCY=1; otherwise WAIT.
- WAIT: lasts RAM_LATENCY-1 cycles, counted by a 2-bit down-counter. ram_en=0. Next state: RESP.
- RESP (1 cycle): the granted master's ack=1. Its rdata passes ram_rdata through combinationally and also captures it into rdata_q. Next state is always IDLE (one bubble cycle).
- Outside RESP, cpu_rdata and dbg_rdata both show rdata_q. For writes, rdata_q is unchanged.
- Starvation counter (8-bit):
  - Increments each cycle dbg_req=1 and DBG is not granted; saturates at MAX_WAIT.
  - Clears on a DBG grant or when dbg_req=0.
  - starve = (count == MAX_WAIT).
- Outside ISSUE, ram_en=0 and ram_wea=0. ram_addr and ram_wdata hold their last values.
- If a master drops req before ack, that is a protocol violation: the transaction still completes and ack still pulses.

## Timing
- Reset values (rst=0 at an edge): state=IDLE, grant=CPU, count=0, rdata_q=0, ram_en=0, ram_wea=0, ram_addr=0, ram_wdata=0, cpu_ack=0, dbg_ack=0. After reset, cpu_ready=!cpu_req.
- Reset mid-transaction discards the access with no ack. A write already issued has reached the RAM.
- Write: req seen in IDLE at cycle c; ISSUE at c+1; ack at c+2; IDLE at c+3.
- Read: ISSUE at c+1; ack at c+1+RAM_LATENCY.
- Minimum spacing between issues is 3 cycles for writes and RAM_LATENCY+2 cycles for reads.
- Simultaneous cpu_req and dbg_req with starve=0: CPU is granted and dbg waits.
- A new request present in the RESP cycle is not seen until the IDLE cycle that follows.
- cpu_ready is combinational from cpu_req and the registered state. No path runs from ram_rdata to any ack.

## Structure
- Package mem_arb_pkg holds: the state enum (IDLE/ISSUE/WAIT/RESP), the master-ID encoding (MST_CPU=0, MST_DBG=1), and the bit widths WEA_W=4 and DATA_W=32.
- The starvation counter is a natural sub-module, arb_starve_cnt: inputs clk, rst, req, grant; output starve; parameter MAX_WAIT.
- Top-level RTL target: roughly 150–250 lines.

## Test plan
- Single CPU word write, with cpu_wea=4'hF, cpu_addr=0x10, cpu_wdata=0xDEADBEEF, RAM_LATENCY=1:
  - Required: ram_en and ram_wea=F in cycle c+1, cpu_ack in c+2, and cpu_ready=0 during c..c+1.
  - Then read 0x10 with RAM_LATENCY=3: required cpu_ack in c+4 with cpu_rdata=0xDEADBEEF.
- Simultaneous cpu_req (read 0x20) and dbg_req (write 0x24): required order is CPU ISSUE first, then DBG ISSUE 3 cycles later, with dbg_ack only after cpu_ack.
- Starvation with MAX_WAIT=4 and back-to-back CPU reads: once dbg_req has been held 4 cycles, the next IDLE grants DBG even though cpu_req=1. The counter then reads 0.
- Reset in WAIT (RAM_LATENCY=3): drop rst for 1 cycle. Required: no ack, state=IDLE, rdata_q=0, and a subsequent read completes normally.
- Idle bus (no req): required cpu_ready=1, ram_en=0, ram_wea=0, and no acks over 20 cycles.
- Byte write (cpu_wea=4'b0100) to 0x32, then word read: only byte lane 2 changes in RAM, and ram_wea=4'b0100 appears only in the ISSUE cycle.
